// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - RV32I opcode and funct7 constants understood by the issue stage
//   - issue_bundle_t: the payload handed to the single-cycle ALU
//   - skid_state_t: occupancy states of the two-entry skid buffer
//   - immediate-forming helpers (sign-extended I-immediate, U-immediate)
// Optional feature macro used by the stage: ALU_ISSUE_LUI_EN.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 7;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;
  localparam int RD_W  = 5;

  localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]  operand1;
    logic [XLEN-1:0]  operand2;
    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [RD_W-1:0]  rd;
    logic             illegal;
  } issue_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  function automatic logic signed [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

  function automatic logic [XLEN-1:0] u_imm(input logic [19:0] imm);
    return {imm, 12'h000};
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with registered in_ready.
//   clk, rst (sync, active-high), flush (sync discard of all entries)
//   in_valid / in_ready / in_data   : upstream side
//   out_valid / out_ready / out_data: downstream side
// in_ready depends only on the registered state, so there is no
// combinational path from out_ready back to in_ready; the skid entry
// absorbs the one bundle that can arrive while the downstream stalls.
module skid_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_p1;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = main_p1;

  // p0 -> p1: main register faces the ALU, skid register holds overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_p1   <= '0;
      skid_p1   <= '0;
    end else if (flush) begin
      // a same-cycle input transfer is dropped along with buffered entries
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_p1   <= in_data;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_p1  <= in_data;
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_p1 <= in_data;
          end else if (out_xfer) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_p1  <= skid_p1;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a raw RV32I instruction plus register-file read
// values into the operand/opcode bundle consumed unchanged by the ALU, and
// presents it through a two-entry skid buffer.
//   clk, rst (sync, active-high), flush (sync discard)
//   in_valid/in_ready, in_instr, in_rs1_val, in_rs2_val : upstream bundle
//   out_valid/out_ready, out_operand1/2, out_opcode, out_funct3,
//   out_funct7, out_rd, out_illegal                     : ALU bundle
//   issue_count : accepted-output count, wraps modulo 2^32
// Optional feature: define ALU_ISSUE_LUI_EN to issue LUI as an ADDI-style
// add of zero and the U-immediate; otherwise LUI is flagged illegal.
// The width parameters must match the package field widths.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter int FUNCT7_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_instr,
  input  logic [DATA_WIDTH-1:0]   in_rs1_val,
  input  logic [DATA_WIDTH-1:0]   in_rs2_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_operand1,
  output logic [DATA_WIDTH-1:0]   out_operand2,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [FUNCT3_WIDTH-1:0] out_funct3,
  output logic [FUNCT7_WIDTH-1:0] out_funct7,
  output logic [4:0]              out_rd,
  output logic                    out_illegal,
  output logic [31:0]             issue_count
);

  localparam int BUNDLE_W = $bits(issue_bundle_t);

  logic [OPCODE_WIDTH-1:0] opc;
  logic [FUNCT3_WIDTH-1:0] f3;
  logic [FUNCT7_WIDTH-1:0] f7;
  logic                    legal_i;
  logic                    unused_rs1_idx;
  issue_bundle_t           dec_p0;
  issue_bundle_t           bundle_p1;
  logic [BUNDLE_W-1:0]     bundle_bits_p1;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // rs1 index is resolved by the register file upstream
  assign unused_rs1_idx = ^in_instr[19:15];

  // Shift-immediates carry funct7 in imm[11:5]; SLLI only accepts the base
  // encoding, SRLI/SRAI accept base or alternate.
  always_comb begin
    legal_i = 1'b1;
    if (f3 == 3'd1) begin
      legal_i = (f7 == F7_BASE);
    end else if (f3 == 3'd5) begin
      legal_i = (f7 == F7_BASE) || (f7 == F7_ALT);
    end
  end

  // p0: combinational decode; an illegal bundle keeps only rd
  always_comb begin
    dec_p0         = '0;
    dec_p0.rd      = in_instr[11:7];
    dec_p0.illegal = 1'b1;
    case (opc)
      OP_RTYPE: begin
        if ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5)))) begin
          dec_p0.operand1 = in_rs1_val;
          dec_p0.operand2 = in_rs2_val;
          dec_p0.opcode   = OP_RTYPE;
          dec_p0.funct3   = f3;
          dec_p0.funct7   = f7;
          dec_p0.illegal  = 1'b0;
        end
      end
      OP_ITYPE: begin
        if (legal_i) begin
          dec_p0.operand1 = in_rs1_val;
          dec_p0.operand2 = $unsigned(sext_imm12(in_instr[31:20]));
          dec_p0.opcode   = OP_ITYPE;
          dec_p0.funct3   = f3;
          dec_p0.funct7   = ((f3 == 3'd1) || (f3 == 3'd5)) ? f7 : F7_BASE;
          dec_p0.illegal  = 1'b0;
        end
      end
`ifdef ALU_ISSUE_LUI_EN
      OP_LUI: begin
        // issued as ADD x0-value + U-immediate
        dec_p0.operand1 = '0;
        dec_p0.operand2 = u_imm(in_instr[31:12]);
        dec_p0.opcode   = OP_ITYPE;
        dec_p0.funct3   = 3'd0;
        dec_p0.funct7   = F7_BASE;
        dec_p0.illegal  = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  skid_buffer #(
    .WIDTH(BUNDLE_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_p0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (bundle_bits_p1)
  );

  assign bundle_p1    = issue_bundle_t'(bundle_bits_p1);
  assign out_operand1 = bundle_p1.operand1;
  assign out_operand2 = bundle_p1.operand2;
  assign out_opcode   = bundle_p1.opcode;
  assign out_funct3   = bundle_p1.funct3;
  assign out_funct7   = bundle_p1.funct7;
  assign out_rd       = bundle_p1.rd;
  assign out_illegal  = bundle_p1.illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
    end else if (out_valid && out_ready) begin
      issue_count <= issue_count + 32'd1;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the single-cycle ALU; the initiator side of the ALU operand/opcode interface.
- Accepts a raw RV32I instruction plus register-file read values and decodes opcode/funct3/funct7.
- Forms operand2 (register value or sign-extended immediate) and presents a registered, valid/ready-handshaked bundle the ALU consumes unchanged.
- Two-entry skid buffer provides full throughput under backpressure.

Parameters:
- DATA_WIDTH, 32, operand/instruction width.
- OPCODE_WIDTH, 7, opcode field width.
- FUNCT3_WIDTH, 3, funct3 field width.
- FUNCT7_WIDTH, 7, funct7 field width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  DATA_WIDTH  raw instruction.
- in_rs1_val  in  DATA_WIDTH  rs1 read value.
- in_rs2_val  in  DATA_WIDTH  rs2 read value.
- out_valid  out  1  issue bundle valid.
- out_ready  in  1  ALU side accepts.
- out_operand1  out  DATA_WIDTH  to ALU operand1.
- out_operand2  out  DATA_WIDTH  to ALU operand2.
- out_opcode  out  OPCODE_WIDTH  to ALU opcode.
- out_funct3  out  FUNCT3_WIDTH  to ALU funct3.
- out_funct7  out  FUNCT7_WIDTH  to ALU funct7.
- out_rd  out  5  destination register.
- out_illegal  out  1  instruction not executable by the ALU.
- issue_count  out  32  accepted-output count, wraps modulo 2^32.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - Latency: 1 cycle from input transfer to out_valid in the EMPTY state.
- States:
  - EMPTY: main register invalid.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY + in_xfer -> ONE.
  - ONE + in_xfer + !out_xfer -> TWO (bundle goes to skid).
  - ONE + out_xfer + !in_xfer -> EMPTY.
  - ONE + both transfers -> ONE (main reloaded).
  - TWO + out_xfer -> ONE (skid moves to main).
  - in_ready = (state != TWO), registered, so no combinational path in_ready <- out_ready.
- Order is preserved; no bundle may be lost or duplicated.
- Reset and flush:
  - Reset: state EMPTY, out_valid 0, in_ready 1, all data outputs 0, issue_count 0.
  - flush: state EMPTY next cycle, in_ready 1. flush beats a same-cycle in_xfer, which is dropped. issue_count is unaffected by flush.
  - rst beats flush. Reset mid-stream discards all entries.
- Decode, R-type (opcode 0110011):
  - operand1 = rs1_val, operand2 = rs2_val, funct7 = instr[31:25].
  - Legal iff funct7 == 0000000, or funct7 == 0100000 with funct3 in {0,5}.
- Decode, I-type (opcode 0010011):
  - operand1 = rs1_val; operand2 = sign-extend(instr[31:20]) to DATA_WIDTH.
  - funct7 = instr[31:25] when funct3 in {1,5}, else 0.
  - SLLI is legal only with instr[31:25] == 0000000.
  - SRLI/SRAI are legal only with instr[31:25] in {0000000, 0100000}.
- Illegal or other opcode: out_illegal = 1, operand1 = operand2 = 0, opcode/funct3/funct7 = 0. The bundle still flows through the handshake.
- out_rd = instr[11:7] always.
- issue_count increments on each output transfer.

Optional Feature:
- Macro: ALU_ISSUE_LUI_EN.
- Defined: LUI (0110111) is legal and is issued as opcode 0010011, funct3 0, funct7 0, operand1 = 0, operand2 = {instr[31:12], 12'b0}, so the ALU computes it as an ADD.
- Undefined: LUI is flagged out_illegal like any other unsupported opcode.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LUI;
  - funct7 constants F7_BASE, F7_ALT;
  - a packed struct issue_bundle_t (operand1, operand2, opcode, funct3, funct7, rd, illegal).
- One sub-module: skid_buffer, parameterized on payload width, holding the EMPTY/ONE/TWO FSM.
- Decode logic stays combinational in the top level.

Test Plan:
- ADD x1,x2,x3 (0x003100B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, opcode 0x33, funct3 0, funct7 0, rd 1, illegal 0.
- ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF, funct7 0, opcode 0x13.
- SRAI x1,x2,3 (0x40315093), rs1=0x80000000 -> op2=0x00000403, funct7 0x20, funct3 5; ALU result 0xF0000000.
- out_ready=0, three back-to-back inputs A,B,C -> in_ready low after B is accepted, C held by upstream; then out_ready=1 -> A,B,C emitted in order, issue_count=3.
- instr 0x00000000 -> out_illegal=1, op1=op2=0; LUI 0x123450B7 -> illegal without the macro, op2=0x12345000 with ALU_ISSUE_LUI_EN.
- State TWO, assert flush alongside in_valid -> next cycle out_valid=0, in_ready=1, the same-cycle input is absent from the output, issue_count unchanged.
